fetch_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 16 +
 rtl/fd_pipe_reg.sv | 26 ++
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: reset/memory defaults and the F/D register payload.
package cpu_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam int          IM_WORDS_DEF = 4096;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        adel;
    } fd_reg_t;

endpackage

// File: rtl/fd_pipe_reg.sv
// Generic pipeline register for fd_reg_t with synchronous clear (priority) and hold.
module fd_pipe_reg
    import cpu_pkg::*;
#(
    parameter fd_reg_t CLR_VAL = '0
) (
    input  logic    clk,
    input  logic    clr_i,
    input  logic    hold_i,
    input  fd_reg_t d_i,
    output fd_reg_t q_o
);

    fd_reg_t data_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= CLR_VAL;
        end else if (!hold_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// F-stage: PC register, next-PC select, fetch legality check and F/D register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallPC,
    input  logic        stallID,
    input  logic        redirect_D,
    input  logic [31:0] target_D,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] redirect_cnt,
    output logic [31:0] fetch_cnt,
`endif
    output logic        adel_D
);

    // End bound kept one bit wider so IM_BASE + 4*IM_WORDS cannot wrap.
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        illegal_f;
    fd_reg_t     fd_d;
    fd_reg_t     fd_q;

    // A stalled PC ignores redirect; the branch re-presents it after release.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (stallPC) begin
            pc_d = pc_q;
        end else if (redirect_D) begin
            pc_d = target_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign illegal_f = (pc_q[1:0] != 2'b00)
                     | (pc_q < IM_BASE)
                     | ({1'b0, pc_q} >= IM_END);

    always_comb begin
        fd_d.instr = illegal_f ? NOP_INSTR : im_rdata;
        fd_d.pc    = pc_q;
        fd_d.adel  = illegal_f;
    end

    fd_pipe_reg #(
        .CLR_VAL('{instr: NOP_INSTR, pc: PC_RESET, adel: 1'b0})
    ) u_fd_reg (
        .clk   (clk),
        .clr_i (reset),
        .hold_i(stallID),
        .d_i   (fd_d),
        .q_o   (fd_q)
    );

    assign im_addr = pc_q;
    assign PC_F    = pc_q;
    assign Instr_D = fd_q.instr;
    assign PC_D    = fd_q.pc;
    assign adel_D  = fd_q.adel;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] redir_cnt_q;
    logic [31:0] fetch_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF)) begin
            return v + 32'd1;
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            redir_cnt_q <= 32'd0;
            fetch_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= sat_inc(stall_cnt_q, stallPC);
            redir_cnt_q <= sat_inc(redir_cnt_q, redirect_D & ~stallPC);
            fetch_cnt_q <= sat_inc(fetch_cnt_q, ~stallPC);
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign redirect_cnt = redir_cnt_q;
    assign fetch_cnt    = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic vs. a cycle model.
module tb_fetch_stage;

    localparam logic [31:0] PC_RST   = 32'h0000_3000;
    localparam logic [31:0] IM_LO    = 32'h0000_3000;
    localparam int          IM_DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stallPC = 1'b0;
    logic        stallID = 1'b0;
    logic        redirect_D = 1'b0;
    logic [31:0] target_D = 32'h0;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] PC_F;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic        adel_D;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] m_pc, m_instr, m_pcd;
    logic        m_adel;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .stallPC   (stallPC),
        .stallID   (stallID),
        .redirect_D(redirect_D),
        .target_D  (target_D),
        .im_addr   (im_addr),
        .im_rdata  (im_rdata),
        .PC_F      (PC_F),
        .Instr_D   (Instr_D),
        .PC_D      (PC_D),
        .adel_D    (adel_D)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign im_rdata = mem_word(im_addr);

    function automatic bit legal_pc(input logic [31:0] a);
        longint ua;
        ua = longint'(a);
        return (ua % 4 == 0) && (ua >= longint'(IM_LO)) &&
               (ua < longint'(IM_LO) + 4 * IM_DEPTH);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the architectural rules, compare.
    task automatic step(input logic r, input logic sp, input logic sid,
                        input logic rd, input logic [31:0] tg);
        logic [31:0] n_pc, n_instr, n_pcd;
        logic        n_adel;
        reset = r; stallPC = sp; stallID = sid; redirect_D = rd; target_D = tg;
        if (r) begin
            n_pc = PC_RST; n_instr = 32'h0; n_pcd = PC_RST; n_adel = 1'b0;
        end else begin
            n_instr = m_instr; n_pcd = m_pcd; n_adel = m_adel;
            if (!sid) begin
                n_adel  = !legal_pc(m_pc);
                n_instr = n_adel ? 32'h0 : mem_word(m_pc);
                n_pcd   = m_pc;
            end
            if (sp)      n_pc = m_pc;
            else if (rd) n_pc = tg;
            else         n_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_adel = n_adel;
        check("pc_f",    PC_F,    m_pc);
        check("im_addr", im_addr, m_pc);
        check("instr_d", Instr_D, m_instr);
        check("pc_d",    PC_D,    m_pcd);
        check("adel_d",  {31'd0, adel_D}, {31'd0, m_adel});
    endtask

    task automatic free_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        m_pc = 32'hx; m_instr = 32'hx; m_pcd = 32'hx; m_adel = 1'bx;

        // Reset for two cycles, then free run
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rst_pc_f",    PC_F,    32'h3000);
        check("rst_instr_d", Instr_D, 32'h0);
        check("rst_pc_d",    PC_D,    32'h3000);
        check("rst_adel_d",  {31'd0, adel_D}, 32'd0);
        repeat (3) free_cycle();
        check("free_pc_f", PC_F, 32'h300C);
        check("free_pc_d", PC_D, 32'h3008);

        // Stall two cycles at PC_F=0x3008
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        free_cycle();
        free_cycle();
        check("pre_stall_pc_f", PC_F, 32'h3008);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("stall_pc_f",    PC_F,    32'h3008);
        check("stall_pc_d",    PC_D,    32'h3004);
        check("stall_instr_d", Instr_D, mem_word(32'h3004));
        free_cycle();
        check("resume_pc_f", PC_F, 32'h300C);

        // Redirect with delay slot: PC_D=0x3004, PC_F=0x3008
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        free_cycle();
        free_cycle();
        check("br_pc_d", PC_D, 32'h3004);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3100);
        check("br_pc_f",    PC_F,    32'h3100);
        check("br_instr_d", Instr_D, mem_word(32'h3008));

        // Redirect presented during stall is ignored until release
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h3200);
        check("stall_redir_pc_f", PC_F, 32'h3100);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3200);
        check("redir_pc_f", PC_F, 32'h3200);

        // Illegal fetches: misaligned then below base
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3002);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000);
        check("mis_instr_d", Instr_D, 32'h0);
        check("mis_adel_d",  {31'd0, adel_D}, 32'd1);
        check("mis_pc_d",    PC_D, 32'h3002);
        free_cycle();
        check("low_instr_d", Instr_D, 32'h0);
        check("low_adel_d",  {31'd0, adel_D}, 32'd1);
        check("low_pc_d",    PC_D, 32'h0000);

        // Top-of-memory boundary: last legal word, then first word past the end
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_6FFC);
        free_cycle();
        check("last_adel_d", {31'd0, adel_D}, 32'd0);
        check("end_pc_f",    PC_F, 32'h0000_7000);
        free_cycle();
        check("end_adel_d",  {31'd0, adel_D}, 32'd1);

        // Reset together with redirect
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3400);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h3100);
        check("rr_pc_f",    PC_F,    32'h3000);
        check("rr_instr_d", Instr_D, 32'h0);
        check("rr_adel_d",  {31'd0, adel_D}, 32'd0);

        // PC wraps modulo 2^32
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        free_cycle();
        check("wrap_pc_f", PC_F, 32'h0000_0000);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        r, sp, sid, rd;
            logic [31:0] tg;
            int          sel;
            r   = ($urandom_range(0, 49) == 0);
            sp  = ($urandom_range(0, 3) == 0);
            sid = ($urandom_range(0, 15) == 0) ? ~sp : sp;
            rd  = ($urandom_range(0, 4) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 7)       tg = IM_LO + 32'($urandom_range(0, IM_DEPTH - 1)) * 4;
            else if (sel == 7) tg = IM_LO + 32'($urandom_range(0, 4 * IM_DEPTH - 1));
            else if (sel == 8) tg = IM_LO + 32'(4 * IM_DEPTH) + 32'($urandom_range(0, 64)) * 4;
            else               tg = $urandom();
            step(r, sp, sid, rd, tg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
